ddr4_axi_memtest: RTL and testbench



---
 rtl/ddr4_axi_memtest.sv | 234 +++++++++++++++++++++++
 tb/tb_ddr4_axi_memtest.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr4_axi_memtest.sv
`default_nettype none
// ==== ddr4_axi_memtest : AXI4 burst write / read-back pattern tester, rev 1.0 ====
// Writes seed^address into num_bursts INCR bursts, reads them back and counts bad beats.

package ddr4_axi_memtest_pkg;
  localparam int unsigned ADDR_W = 64;
  localparam int unsigned DATA_W = 128;
  localparam int unsigned ID_W   = 4;
  localparam int unsigned USER_W = 1;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        len;
    logic [2:0]        size;
    logic [1:0]        burst;
    logic              lock;
    logic [3:0]        cache;
    logic [2:0]        prot;
    logic [3:0]        qos;
    logic [3:0]        region;
    logic [5:0]        atop;
    logic [USER_W-1:0] user;
  } aw_chan_t;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        len;
    logic [2:0]        size;
    logic [1:0]        burst;
    logic              lock;
    logic [3:0]        cache;
    logic [2:0]        prot;
    logic [3:0]        qos;
    logic [3:0]        region;
    logic [USER_W-1:0] user;
  } ar_chan_t;

  typedef struct packed {
    logic [DATA_W-1:0]   data;
    logic [DATA_W/8-1:0] strb;
    logic                last;
    logic [USER_W-1:0]   user;
  } w_chan_t;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [1:0]        resp;
    logic [USER_W-1:0] user;
  } b_chan_t;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
    logic [1:0]        resp;
    logic              last;
    logic [USER_W-1:0] user;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } axi_req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } axi_resp_t;
endpackage

module ddr4_axi_memtest #(
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned DataWidth = 128,
  parameter int unsigned IdWidth   = 4,
  parameter int unsigned BurstLen  = 16,
  parameter type axi_req_t  = ddr4_axi_memtest_pkg::axi_req_t,
  parameter type axi_resp_t = ddr4_axi_memtest_pkg::axi_resp_t
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [AddrWidth-1:0] base_addr_i,
  input  logic [15:0]          num_bursts_i,
  input  logic [31:0]          seed_i,
  output axi_req_t             mst_req_o,
  input  axi_resp_t            mst_rsp_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [31:0]          err_cnt_o,
  output logic [AddrWidth-1:0] first_err_addr_o
);

  localparam int unsigned BeatBytes  = DataWidth / 8;
  localparam int unsigned BurstBytes = BurstLen * BeatBytes;
  localparam int unsigned SizeLog    = $clog2(BeatBytes);
  localparam int unsigned BeatW      = $clog2(BurstLen + 1);
  localparam int unsigned Reps       = DataWidth / 32;
  localparam logic [7:0]  LenField   = 8'(BurstLen - 1);
  localparam logic [2:0]  SizeField  = 3'(SizeLog);
  localparam logic [IdWidth-1:0] TxnId = '0;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WR_AW = 3'd1;
  localparam logic [2:0] S_WR_W  = 3'd2;
  localparam logic [2:0] S_WR_B  = 3'd3;
  localparam logic [2:0] S_RD_AR = 3'd4;
  localparam logic [2:0] S_RD_R  = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  logic [2:0]           state, state_nxt;
  logic [AddrWidth-1:0] base, burst_addr, beat_addr, err_addr;
  logic [15:0]          num_bursts, burst_k;
  logic [31:0]          seed;
  logic [BeatW-1:0]     beat;
  logic [DataWidth-1:0] exp_data;
  logic                 start_ok, last_beat, more_bursts;
  logic                 w_hs, b_hs, r_hs, r_bad, b_bad, err_evt;
  logic                 unused_rsp;

  assign beat_addr   = burst_addr + (AddrWidth'(beat) << SizeLog);
  assign exp_data    = {Reps{seed ^ beat_addr[31:0]}};
  assign last_beat   = (beat == BeatW'(BurstLen - 1));
  assign more_bursts = (17'(burst_k) + 17'd1) < 17'(num_bursts);
  assign start_ok    = start_i && (state == S_IDLE || state == S_DONE);

  assign w_hs  = (state == S_WR_W) && mst_rsp_i.w_ready;
  assign b_hs  = (state == S_WR_B) && mst_rsp_i.b_valid;
  assign r_hs  = (state == S_RD_R) && mst_rsp_i.r_valid;
  assign b_bad = b_hs && (mst_rsp_i.b.resp != 2'b00);
  // Data, response and last-position faults on one beat collapse into a single error.
  assign r_bad = r_hs && ((mst_rsp_i.r.data != exp_data) || (mst_rsp_i.r.resp != 2'b00)
                          || (mst_rsp_i.r.last != last_beat));
  assign err_evt  = b_bad || r_bad;
  assign err_addr = b_bad ? burst_addr : beat_addr;

  assign unused_rsp = ^{mst_rsp_i.b.id, mst_rsp_i.b.user, mst_rsp_i.r.id, mst_rsp_i.r.user};

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (start_i) state_nxt = (num_bursts_i == 16'd0) ? S_DONE : S_WR_AW;
      S_WR_AW:        if (mst_rsp_i.aw_ready) state_nxt = S_WR_W;
      S_WR_W:         if (mst_rsp_i.w_ready && last_beat) state_nxt = S_WR_B;
      S_WR_B:         if (mst_rsp_i.b_valid) state_nxt = more_bursts ? S_WR_AW : S_RD_AR;
      S_RD_AR:        if (mst_rsp_i.ar_ready) state_nxt = S_RD_R;
      S_RD_R:         if (mst_rsp_i.r_valid && mst_rsp_i.r.last)
                        state_nxt = more_bursts ? S_RD_AR : S_DONE;
      default:        state_nxt = S_IDLE;
    endcase
  end

  // Valids and readies are pure decodes of the state register, never of a ready input.
  always_comb begin
    mst_req_o          = '0;
    mst_req_o.aw.id    = TxnId;
    mst_req_o.aw.addr  = burst_addr;
    mst_req_o.aw.len   = LenField;
    mst_req_o.aw.size  = SizeField;
    mst_req_o.aw.burst = 2'b01;
    mst_req_o.ar.id    = TxnId;
    mst_req_o.ar.addr  = burst_addr;
    mst_req_o.ar.len   = LenField;
    mst_req_o.ar.size  = SizeField;
    mst_req_o.ar.burst = 2'b01;
    mst_req_o.w.data   = exp_data;
    mst_req_o.w.strb   = '1;
    mst_req_o.w.last   = last_beat;
    mst_req_o.aw_valid = (state == S_WR_AW);
    mst_req_o.w_valid  = (state == S_WR_W);
    mst_req_o.b_ready  = (state == S_WR_B);
    mst_req_o.ar_valid = (state == S_RD_AR);
    mst_req_o.r_ready  = (state == S_RD_R);
    busy_o             = (state != S_IDLE) && (state != S_DONE);
    done_o             = (state == S_DONE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      base             <= '0;
      burst_addr       <= '0;
      num_bursts       <= '0;
      seed             <= '0;
      burst_k          <= '0;
      beat             <= '0;
      err_cnt_o        <= '0;
      first_err_addr_o <= '0;
    end else if (start_ok) begin
      base             <= base_addr_i;
      burst_addr       <= base_addr_i;
      num_bursts       <= num_bursts_i;
      seed             <= seed_i;
      burst_k          <= '0;
      beat             <= '0;
      err_cnt_o        <= '0;
      first_err_addr_o <= '0;
    end else begin
      if (w_hs) beat <= last_beat ? '0 : beat + 1'b1;
      if (r_hs) beat <= mst_rsp_i.r.last ? '0 : beat + 1'b1;
      // End of a burst: step to the next one, or rewind to base for the read-back pass.
      if (b_hs || (r_hs && mst_rsp_i.r.last)) begin
        if (more_bursts) begin
          burst_k    <= burst_k + 16'd1;
          burst_addr <= burst_addr + AddrWidth'(BurstBytes);
        end else begin
          burst_k    <= '0;
          burst_addr <= base;
        end
      end
      if (err_evt && (err_cnt_o != 32'hFFFF_FFFF)) begin
        err_cnt_o <= err_cnt_o + 32'd1;
        if (err_cnt_o == 32'd0) first_err_addr_o <= err_addr;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ddr4_axi_memtest.sv
`default_nettype none
// ==== tb_ddr4_axi_memtest : randomized bench with an AXI memory model, rev 1.0 ====
module tb_ddr4_axi_memtest;
  import ddr4_axi_memtest_pkg::*;

  localparam int          BL      = 16;
  localparam logic [63:0] BEAT_B  = 64'd16;
  localparam logic [63:0] BURST_B = 64'd256;
  localparam int          TIMEOUT = 5000;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [63:0] base;
  logic [15:0] num;
  logic [31:0] seed;
  axi_req_t    req;
  axi_resp_t   rsp;
  logic        busy, done;
  logic [31:0] err_cnt;
  logic [63:0] first_err;

  always #5 clk = ~clk;

  ddr4_axi_memtest #(
    .AddrWidth(64), .DataWidth(128), .IdWidth(4), .BurstLen(BL)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .base_addr_i(base),
    .num_bursts_i(num), .seed_i(seed), .mst_req_o(req), .mst_rsp_i(rsp),
    .busy_o(busy), .done_o(done), .err_cnt_o(err_cnt), .first_err_addr_o(first_err)
  );

  int checks = 0;
  int failures = 0;

  // Memory / subordinate model state
  logic [127:0] mem [logic [63:0]];
  bit           b_slv [int];
  bit           r_slv [int];
  bit           r_cor [int];
  int           aw_n, w_n, b_n, ar_n, r_n;
  int           field_err, wdata_err, stab_err, excl_err, valid_seen;
  int           aw_wait, w_wait, ar_wait;
  bit           bp;
  logic [63:0]  cur_base;
  logic [31:0]  cur_seed;
  bit           w_active, b_pend, r_pend;
  logic [63:0]  w_addr, r_addr;
  int           w_beat, w_burst, r_beat, r_burst;
  bit           p_aw_v, p_aw_r, p_w_v, p_w_r, p_ar_v, p_ar_r;
  aw_chan_t     p_aw;
  w_chan_t      p_w;
  ar_chan_t     p_ar;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] pat(input logic [31:0] s, input logic [63:0] a);
    return {4{s ^ a[31:0]}};
  endfunction

  function automatic bit aw_ok(input aw_chan_t c, input logic [63:0] a);
    return c.addr === a && c.len === 8'd15 && c.size === 3'd4 && c.burst === 2'b01 &&
           c.id === 4'd0 && c.lock === 1'b0 && c.cache === 4'd0 && c.prot === 3'd0 &&
           c.qos === 4'd0 && c.region === 4'd0 && c.atop === 6'd0 && c.user === 1'b0;
  endfunction

  function automatic bit ar_ok(input ar_chan_t c, input logic [63:0] a);
    return c.addr === a && c.len === 8'd15 && c.size === 3'd4 && c.burst === 2'b01 &&
           c.id === 4'd0 && c.lock === 1'b0 && c.cache === 4'd0 && c.prot === 3'd0 &&
           c.qos === 4'd0 && c.region === 4'd0 && c.user === 1'b0;
  endfunction

  task automatic clear_model();
    aw_n = 0; w_n = 0; b_n = 0; ar_n = 0; r_n = 0;
    field_err = 0; wdata_err = 0; stab_err = 0; excl_err = 0; valid_seen = 0;
    aw_wait = 0; w_wait = 0; ar_wait = 0;
    w_active = 0; b_pend = 0; r_pend = 0;
    w_addr = '0; r_addr = '0; w_beat = 0; w_burst = 0; r_beat = 0; r_burst = 0;
    p_aw_v = 0; p_aw_r = 0; p_w_v = 0; p_w_r = 0; p_ar_v = 0; p_ar_r = 0;
    p_aw = '0; p_w = '0; p_ar = '0;
    mem.delete();
    rsp = '0;
  endtask

  task automatic clear_inject();
    b_slv.delete(); r_slv.delete(); r_cor.delete();
  endtask

  // Expected outcome straight from the rules: write-phase errors come first, one per bad beat.
  task automatic calc_expect(input logic [63:0] b, input int n,
                             output logic [31:0] e_err, output logic [63:0] e_first);
    bit found = 0;
    e_err = 0; e_first = '0;
    for (int k = 0; k < n; k++)
      if (b_slv.exists(k)) begin
        e_err++;
        if (!found) begin e_first = b + 64'(k) * BURST_B; found = 1; end
      end
    for (int k = 0; k < n; k++)
      for (int i = 0; i < BL; i++)
        if (r_cor.exists(k * 256 + i) || r_slv.exists(k * 256 + i)) begin
          e_err++;
          if (!found) begin e_first = b + 64'(k) * BURST_B + 64'(i) * BEAT_B; found = 1; end
        end
  endtask

  // One subordinate cycle, called just after a rising edge; decides responses for the next edge.
  task automatic step();
    logic [63:0]  ra, wa;
    logic [127:0] d;
    int           id;
    if (p_aw_v && !p_aw_r && (!req.aw_valid || req.aw != p_aw)) stab_err++;
    if (p_w_v && !p_w_r && (!req.w_valid || req.w != p_w)) stab_err++;
    if (p_ar_v && !p_ar_r && (!req.ar_valid || req.ar != p_ar)) stab_err++;
    if (int'(req.aw_valid) + int'(req.w_valid) + int'(req.ar_valid) +
        int'(req.b_ready) + int'(req.r_ready) > 1) excl_err++;
    if (req.aw_valid || req.w_valid || req.ar_valid) valid_seen++;

    rsp = '0;
    if (req.aw_valid) begin
      if (!p_aw_v || p_aw_r) aw_wait = bp ? int'($urandom_range(0, 7)) : 0;
      rsp.aw_ready = (aw_wait == 0);
      if (aw_wait > 0) aw_wait--;
    end
    if (req.w_valid) begin
      if (!p_w_v || p_w_r) w_wait = bp ? int'($urandom_range(0, 7)) : 0;
      rsp.w_ready = (w_wait == 0);
      if (w_wait > 0) w_wait--;
    end
    if (req.ar_valid) begin
      if (!p_ar_v || p_ar_r) ar_wait = bp ? int'($urandom_range(0, 7)) : 0;
      rsp.ar_ready = (ar_wait == 0);
      if (ar_wait > 0) ar_wait--;
    end
    rsp.b_valid = b_pend;
    rsp.b.resp  = (b_pend && b_slv.exists(w_burst)) ? 2'b10 : 2'b00;
    if (r_pend) begin
      ra = r_addr + 64'(r_beat) * BEAT_B;
      id = r_burst * 256 + r_beat;
      d  = mem.exists(ra) ? mem[ra] : '0;
      if (r_cor.exists(id)) d[0] = ~d[0];
      rsp.r_valid = 1'b1;
      rsp.r.data  = d;
      rsp.r.resp  = r_slv.exists(id) ? 2'b10 : 2'b00;
      rsp.r.last  = (r_beat == BL - 1);
    end

    if (rsp.b_valid && req.b_ready) begin b_n++; b_pend = 0; end
    if (rsp.r_valid && req.r_ready) begin
      r_n++; r_beat++;
      if (r_beat == BL) r_pend = 0;
    end
    if (req.aw_valid && rsp.aw_ready) begin
      if (!aw_ok(req.aw, cur_base + 64'(aw_n) * BURST_B)) field_err++;
      w_active = 1; w_addr = req.aw.addr; w_beat = 0; w_burst = aw_n; aw_n++;
    end
    if (req.w_valid && rsp.w_ready) begin
      wa = w_addr + 64'(w_beat) * BEAT_B;
      if (!w_active || req.w.data !== pat(cur_seed, wa) || req.w.strb !== 16'hFFFF ||
          req.w.last !== (w_beat == BL - 1)) wdata_err++;
      mem[wa] = req.w.data;
      w_n++; w_beat++;
      if (req.w.last) begin w_active = 0; b_pend = 1; end
    end
    if (req.ar_valid && rsp.ar_ready) begin
      if (!ar_ok(req.ar, cur_base + 64'(ar_n) * BURST_B)) field_err++;
      r_pend = 1; r_addr = req.ar.addr; r_beat = 0; r_burst = ar_n; ar_n++;
    end

    p_aw_v = req.aw_valid; p_aw_r = rsp.aw_ready; p_aw = req.aw;
    p_w_v  = req.w_valid;  p_w_r  = rsp.w_ready;  p_w  = req.w;
    p_ar_v = req.ar_valid; p_ar_r = rsp.ar_ready; p_ar = req.ar;
  endtask

  task automatic run_test(input logic [63:0] b, input logic [15:0] n, input logic [31:0] s,
                          input bit bp_i, input bit poke, input logic [31:0] exp_err,
                          input logic [63:0] exp_first);
    int cyc = 0;
    clear_model();
    bp = bp_i; cur_base = b; cur_seed = s;
    base = b; num = n; seed = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; base = ~b; num = ~n; seed = ~s;
    check("err_clear_on_start", err_cnt, 0);
    check("first_clear_on_start", first_err, 0);
    if (n == 0) begin
      check("done_next_cycle", done, 1);
      check("busy_low_when_empty", busy, 0);
    end else begin
      check("busy_after_start", busy, 1);
    end
    while (!done && cyc < TIMEOUT) begin
      if (poke) start = busy && ($urandom_range(0, 15) == 0);
      step();
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    repeat (3) begin step(); @(posedge clk); #1; end
    check("no_timeout", cyc < TIMEOUT, 1);
    check("aw_count", aw_n, n);
    check("w_count", w_n, 64'(n) * BL);
    check("b_count", b_n, n);
    check("ar_count", ar_n, n);
    check("r_count", r_n, 64'(n) * BL);
    check("addr_fields", field_err, 0);
    check("w_payload", wdata_err, 0);
    check("stable_while_stalled", stab_err, 0);
    check("one_channel_active", excl_err, 0);
    if (n == 0) check("no_valid_when_empty", valid_seen, 0);
    check("done_held", done, 1);
    check("busy_low_in_done", busy, 0);
    check("err_cnt", err_cnt, exp_err);
    check("first_err_addr", first_err, exp_first);
  endtask

  logic [63:0] rb, e_first;
  logic [15:0] rn;
  logic [31:0] rs, e_err;
  int          cyc_r, rid;

  initial begin
    rst = 1'b1; start = 1'b0; base = '0; num = '0; seed = '0; bp = 0;
    clear_model(); clear_inject();
    repeat (3) @(posedge clk);
    #1;
    check("rst_aw_valid", req.aw_valid, 0);
    check("rst_w_valid", req.w_valid, 0);
    check("rst_b_ready", req.b_ready, 0);
    check("rst_ar_valid", req.ar_valid, 0);
    check("rst_r_ready", req.r_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_first_err", first_err, 0);
    rst = 1'b0;

    // Clean two-burst run, zero wait states
    run_test(64'h1000, 16'd2, 32'h0, 0, 0, 32'd0, 64'h0);

    // Single-bit corruption, beat 3 of read burst 1
    clear_inject(); r_cor[1 * 256 + 3] = 1;
    run_test(64'h1000, 16'd2, 32'h0, 0, 0, 32'd1, 64'h1130);

    // Empty job
    clear_inject();
    run_test(64'h1000, 16'd0, 32'h0, 0, 0, 32'd0, 64'h0);

    // Ready back-pressure with stray start pulses while busy
    clear_inject();
    run_test(64'h1000, 16'd2, $urandom, 1, 1, 32'd0, 64'h0);

    // Write response error on burst 0 plus two read response errors
    clear_inject(); b_slv[0] = 1; r_slv[5] = 1; r_slv[256 + 9] = 1;
    run_test(64'h1000, 16'd2, 32'hCAFE_0001, 0, 0, 32'd3, 64'h1000);

    // Reset in the middle of the write data phase
    clear_inject(); clear_model();
    bp = 0; cur_base = 64'h1000; cur_seed = 32'h5A5A;
    base = 64'h1000; num = 16'd2; seed = 32'h5A5A; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc_r = 0;
    while (w_n < 3 && cyc_r < 200) begin step(); @(posedge clk); #1; cyc_r++; end
    check("reached_wr_w", req.w_valid, 1);
    rsp = '0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_w_valid", req.w_valid, 0);
    check("mid_rst_aw_valid", req.aw_valid, 0);
    check("mid_rst_b_ready", req.b_ready, 0);
    check("mid_rst_ar_valid", req.ar_valid, 0);
    check("mid_rst_r_ready", req.r_ready, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_err_cnt", err_cnt, 0);
    check("mid_rst_first_err", first_err, 0);
    run_test(64'h1000, 16'd2, 32'h5A5A, 0, 0, 32'd0, 64'h0);

    // Random jobs with random fault injection
    for (int it = 0; it < 4; it++) begin
      rb = {32'($urandom), 32'($urandom)} & ~64'hFF;
      rn = 16'($urandom_range(1, 4));
      rs = $urandom;
      clear_inject();
      for (int k = 0; k < int'(rn); k++)
        if ($urandom_range(0, 3) == 0) b_slv[k] = 1;
      for (int j = 0; j < 3; j++) begin
        rid = int'($urandom_range(0, int'(rn) - 1)) * 256 + int'($urandom_range(0, BL - 1));
        if ($urandom_range(0, 1) == 0) r_cor[rid] = 1;
        else r_slv[rid] = 1;
      end
      calc_expect(rb, int'(rn), e_err, e_first);
      run_test(rb, rn, rs, 1, 1, e_err, e_first);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
